// File: rtl/spart_tx.sv
// spart_tx: sends a 24-bit message on txd as three back-to-back 8N1 characters, LSB byte first.
//   state | meaning
//   IDLE  | line high, waiting for send_tx
//   START | start bit (0) of the current character
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (1); chains into the next character or finishes the message
module spart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200,
    parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        send_tx,
    input  logic [23:0] tx_data,
    output logic        txd,
    output logic        busy,
    output logic        tx_done
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [1:0]    byte_idx, byte_idx_nxt;
    logic [7:0]    shift_reg, shift_reg_nxt;
    logic [23:0]   hold, hold_nxt;
    logic          txd_nxt, busy_nxt, tx_done_nxt;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_nxt     = state;
        baud_cnt_nxt  = baud_cnt;
        bit_idx_nxt   = bit_idx;
        byte_idx_nxt  = byte_idx;
        shift_reg_nxt = shift_reg;
        hold_nxt      = hold;
        txd_nxt       = txd;
        busy_nxt      = busy;
        tx_done_nxt   = 1'b0;

        if (state != IDLE) begin
            baud_cnt_nxt = bit_end ? '0 : baud_cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                if (send_tx) begin
                    hold_nxt      = tx_data;
                    shift_reg_nxt = tx_data[7:0];
                    byte_idx_nxt  = '0;
                    bit_idx_nxt   = '0;
                    state_nxt     = START;
                    txd_nxt       = 1'b0;
                    busy_nxt      = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                    txd_nxt     = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        bit_idx_nxt   = bit_idx + 3'd1;
                        shift_reg_nxt = shift_reg >> 1;
                        txd_nxt       = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx == 2'd2) begin
                        state_nxt    = IDLE;
                        byte_idx_nxt = '0;
                        busy_nxt     = 1'b0;
                        tx_done_nxt  = 1'b1;
                    end else begin
                        // rotate so the next character always sits in hold[15:8]
                        byte_idx_nxt  = byte_idx + 2'd1;
                        shift_reg_nxt = hold[15:8];
                        hold_nxt      = {hold[7:0], hold[23:8]};
                        state_nxt     = START;
                        txd_nxt       = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
            hold      <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            byte_idx  <= byte_idx_nxt;
            shift_reg <= shift_reg_nxt;
            hold      <= hold_nxt;
            txd       <= txd_nxt;
            busy      <= busy_nxt;
            tx_done   <= tx_done_nxt;
        end
    end
endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx with BAUD_DIV=4: vector table of frames, hand-built corner sequences,
// random traffic, all checked against a per-cycle reference derived from frame arithmetic.
module tb_spart_tx;
    localparam int D     = 4;
    localparam int CHAR  = 10 * D;
    localparam int FRAME = 30 * D;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        send_tx = 1'b0;
    logic [23:0] tx_data = '0;
    logic        txd, busy, tx_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    spart_tx #(.BAUD_DIV(D)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .send_tx (send_tx),
        .tx_data (tx_data),
        .txd     (txd),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: remembers the accept cycle and data of the current message only.
    int          cyc    = 0;
    bit          m_have = 1'b0;
    int          m_n    = 0;
    logic [23:0] m_data = '0;

    always @(posedge sys_clk) begin
        if (!rst_n) begin
            m_have <= 1'b0;
        end else if (send_tx && (!m_have || (cyc - m_n - 1) >= FRAME)) begin
            m_have <= 1'b1;
            m_n    <= cyc;
            m_data <= tx_data;
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    logic e_txd, e_busy, e_done;

    always @(negedge sys_clk) begin
        if (checking) begin
            int t;
            int k;
            int b;
            t      = cyc - m_n - 1;
            e_txd  = 1'b1;
            e_busy = 1'b0;
            e_done = 1'b0;
            if (m_have && t >= 0 && t < FRAME) begin
                k      = t / CHAR;
                b      = (t % CHAR) / D;
                e_busy = 1'b1;
                if (b == 0)      e_txd = 1'b0;
                else if (b == 9) e_txd = 1'b1;
                else             e_txd = m_data[8*k + b - 1];
            end else if (m_have && t == FRAME) begin
                e_done = 1'b1;
            end
            check("model_txd", 32'(txd), 32'(e_txd));
            check("model_busy", 32'(busy), 32'(e_busy));
            check("model_tx_done", 32'(tx_done), 32'(e_done));
        end
    end

    // Called at a negedge while the transmitter is idle (or in its tx_done cycle).
    // Returns at the negedge of the expected tx_done cycle N+121.
    task automatic run_frame(input logic [23:0] data, input logic [29:0] pat, input bit inject);
        logic [23:0] got;
        got     = '0;
        send_tx = 1'b1;
        tx_data = data;
        @(negedge sys_clk);
        send_tx = 1'b0;
        check("frame_first_txd", 32'(txd), 32'd0);
        check("frame_first_busy", 32'(busy), 32'd1);
        @(negedge sys_clk);
        for (int i = 0; i < 30; i++) begin
            check("frame_bit", 32'(txd), 32'(pat[29-i]));
            if ((i % 10) >= 1 && (i % 10) <= 8) got[(i / 10) * 8 + (i % 10) - 1] = txd;
            if (inject && i == 12) begin
                send_tx = 1'b1;
                tx_data = 24'hFFFFFF;
            end
            @(negedge sys_clk);
            send_tx = 1'b0;
            if (i != 29) repeat (3) @(negedge sys_clk);
        end
        repeat (2) @(negedge sys_clk);
        check("frame_tx_done", 32'(tx_done), 32'd1);
        check("frame_busy_low", 32'(busy), 32'd0);
        check("loopback_data", 32'(got), 32'(data));
    endtask

    typedef struct {
        logic [23:0] data;
        logic [29:0] pat;
        bit          inject;
        int          gap;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{24'hA53C81, 30'b0100000011_0001111001_0101001011, 1'b1, 3};
        vecs[1] = '{24'h000000, 30'b0000000001_0000000001_0000000001, 1'b0, 0};
        vecs[2] = '{24'hFFFFFF, 30'b0111111111_0111111111_0111111111, 1'b0, 7};
        vecs[3] = '{24'h123456, 30'b0011010101_0001011001_0010010001, 1'b0, 2};

        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checking = 1'b1;
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tx_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            check("idle_txd", 32'(txd), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
        end

        foreach (vecs[v]) begin
            repeat (vecs[v].gap) @(negedge sys_clk);
            run_frame(vecs[v].data, vecs[v].pat, vecs[v].inject);
        end

        // abandon a frame with reset at N+40
        repeat (5) @(negedge sys_clk);
        send_tx = 1'b1;
        tx_data = 24'hA53C81;
        @(negedge sys_clk);
        send_tx = 1'b0;
        repeat (39) @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        check("midreset_txd", 32'(txd), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_tx_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge sys_clk);
            check("midreset_no_done", 32'(tx_done), 32'd0);
        end
        run_frame(vecs[0].data, vecs[0].pat, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            send_tx = ($urandom_range(0, 9) == 0);
            tx_data = 24'($urandom);
            rst_n   = ($urandom_range(0, 799) != 0);
        end
        @(negedge sys_clk);
        send_tx = 1'b0;
        rst_n   = 1'b1;
        repeat (FRAME + 5) @(negedge sys_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
